ram_dump_tx: RTL



---
 rtl/ram_dump_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 76 +++++++
 rtl/ram_dump_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ram_dump_pkg.sv
// Shared FSM encodings and UART framing constants for the RAM dump transmitter.
package ram_dump_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_READ = 3'd1;
   localparam state_t ST_WAIT = 3'd2;
   localparam state_t ST_SEND = 3'd3;
   localparam state_t ST_NEXT = 3'd4;
   localparam state_t ST_CSUM = 3'd5;
   localparam state_t ST_FIN  = 3'd6;

   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;
   localparam int unsigned FRAME_BITS = 10;

   // Counter width that stays legal when the range collapses to a single value.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A byte offered on the cycle of byte_done chains
// back-to-back: its start bit follows the stop bit with no idle cycle.
module uart_tx_byte
   import ram_dump_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       byte_done,
   output logic       tx
);

   localparam int unsigned CntW = clog2_min1(CLKS_PER_BIT);
   localparam int unsigned BitW = clog2_min1(FRAME_BITS);

   logic                  active_q, active_d;
   logic [CntW-1:0]       baud_q, baud_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  last_tick;

   assign last_tick  = active_q && (baud_q == CntW'(CLKS_PER_BIT - 1));
   assign byte_done  = last_tick && (bit_q == BitW'(FRAME_BITS - 1));
   assign byte_ready = !active_q || byte_done;
   assign tx         = tx_q;

   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      if (active_q) begin
         if (last_tick) begin
            baud_d = '0;
            if (byte_done) begin
               active_d = 1'b0;
            end else begin
               bit_d   = bit_q + 1'b1;
               shift_d = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
            end
         end else begin
            baud_d = baud_q + 1'b1;
         end
      end
      if (byte_valid && byte_ready) begin
         active_d = 1'b1;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = {STOP_BIT, byte_data, START_BIT};
      end
      // Registered line: tx reflects the bit that will be on the wire next cycle.
      tx_d = active_d ? shift_d[0] : STOP_BIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
         tx_q     <= STOP_BIT;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: rtl/ram_dump_tx.sv
// Reads a window of RAM and sends it over UART, MSB byte of each word first.
// Define RAM_DUMP_CHECKSUM_EN to append a two's-complement checksum byte.
module ram_dump_tx
   import ram_dump_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned DATA_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_rd_en,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned NBytes = DATA_WIDTH / 8;
   localparam int unsigned IdxW   = clog2_min1(NBytes);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [ADDR_WIDTH:0]   rem_dec;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [DATA_WIDTH-1:0] word_shl;
   logic [IdxW-1:0]       idx_q, idx_d;
`ifdef RAM_DUMP_CHECKSUM_EN
   logic [7:0]            sum_q, sum_d;
`endif

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       byte_done;

   assign rem_dec   = rem_q - 1'b1;
   assign word_shl  = word_q << 8;
   assign ram_addr  = addr_q;
   assign ram_rd_en = (state_q == ST_READ);
   assign done      = (state_q == ST_FIN);
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      word_d     = word_q;
      idx_d      = idx_q;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d = base_addr;
               rem_d  = word_count;
`ifdef RAM_DUMP_CHECKSUM_EN
               sum_d  = 8'h00;
`endif
               if (word_count == '0) begin
`ifdef RAM_DUMP_CHECKSUM_EN
                  byte_valid = 1'b1;
                  byte_data  = 8'h00;
                  state_d    = ST_CSUM;
`else
                  state_d    = ST_FIN;
`endif
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: state_d = ST_WAIT;
         ST_WAIT: begin
            // First byte goes straight from the RAM port so its start bit lands in SEND.
            if (byte_ready) begin
               word_d     = ram_rdata;
               idx_d      = IdxW'(NBytes - 1);
               byte_valid = 1'b1;
               byte_data  = ram_rdata[DATA_WIDTH-1 -: 8];
`ifdef RAM_DUMP_CHECKSUM_EN
               sum_d      = sum_q + ram_rdata[DATA_WIDTH-1 -: 8];
`endif
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (byte_done) begin
               if (idx_q != '0) begin
                  word_d     = word_shl;
                  idx_d      = idx_q - 1'b1;
                  byte_valid = 1'b1;
                  byte_data  = word_shl[DATA_WIDTH-1 -: 8];
`ifdef RAM_DUMP_CHECKSUM_EN
                  sum_d      = sum_q + word_shl[DATA_WIDTH-1 -: 8];
`endif
               end else begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_dec;
            if (rem_dec != '0) begin
               state_d = ST_READ;
            end else begin
`ifdef RAM_DUMP_CHECKSUM_EN
               byte_valid = 1'b1;
               byte_data  = ~sum_q + 8'd1;
               state_d    = ST_CSUM;
`else
               state_d    = ST_FIN;
`endif
            end
         end
         ST_CSUM: begin
            if (byte_done) state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         word_q  <= '0;
         idx_q   <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
         sum_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
`ifdef RAM_DUMP_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx_byte (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .byte_done (byte_done),
      .tx        (tx)
   );

endmodule
